// File: rtl/demux_1_to_2_buffered_pkg.sv
// Shared definitions for the buffered 1-to-2 demux: route-select encodings and default sizing.
// CTRL encodings follow the existing 2-to-1 mux select convention.
package demux_1_to_2_buffered_pkg;

    localparam int DEF_BITWIDTH = 32;
    localparam int DEF_DEPTH    = 2;
    localparam int DEF_CNTW     = 2;

    typedef enum logic {
        SEL_OUT_1 = 1'b0,
        SEL_OUT_2 = 1'b1
    } sel_e;

endpackage

// File: rtl/demux_1_to_2_buffered_if.sv
// Stream bundle for the buffered demux: one steered input stream, two output streams, occupancies.
// The slave modport is the demux side; master is the issue/consumer side.
import demux_1_to_2_buffered_pkg::*;

interface demux_1_to_2_buffered_if #(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int CNTW     = DEF_CNTW
);
    logic [BITWIDTH-1:0] in_data;
    logic                in_valid;
    logic                CTRL;
    logic                in_ready;
    logic [BITWIDTH-1:0] out_1_data;
    logic                out_1_valid;
    logic                out_1_ready;
    logic [BITWIDTH-1:0] out_2_data;
    logic                out_2_valid;
    logic                out_2_ready;
    logic [CNTW-1:0]     count_1;
    logic [CNTW-1:0]     count_2;

    modport master (
        output in_data, in_valid, CTRL, out_1_ready, out_2_ready,
        input  in_ready, out_1_data, out_1_valid, out_2_data, out_2_valid, count_1, count_2
    );

    modport slave (
        input  in_data, in_valid, CTRL, out_1_ready, out_2_ready,
        output in_ready, out_1_data, out_1_valid, out_2_data, out_2_valid, count_1, count_2
    );

endinterface

// File: rtl/demux_1_to_2_buffered_fifo.sv
// Single-clock FIFO for one demux channel: head visible the cycle after push, zero when empty.
// Push is dropped when full; pop only on head_valid & pop_ready; flush/rst empty it in one cycle.
module demux_fifo #(
    parameter int BITWIDTH = 32,
    parameter int DEPTH    = 2,
    parameter int CNTW     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                push,
    input  logic [BITWIDTH-1:0] push_data,
    input  logic                pop_ready,
    output logic [BITWIDTH-1:0] head_data,
    output logic                head_valid,
    output logic [CNTW-1:0]     count
);
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BITWIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]     wr_ptr;
    logic [PTRW-1:0]     rd_ptr;
    logic [CNTW-1:0]     cnt;
    logic                do_push;
    logic                do_pop;
    logic                clr;

    assign clr        = rst || flush;
    assign head_valid = (cnt != '0);
    assign do_pop     = head_valid && pop_ready && !clr;
    assign do_push    = push && (cnt != CNTW'(DEPTH)) && !clr;
    assign count      = cnt;
    // Head is masked while empty so stale or uninitialised storage never leaks out.
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/demux_1_to_2_buffered.sv
// Buffered 1-to-2 stream demux: CTRL steers each input word into a per-channel FIFO, 1-cycle latency.
// in_ready reflects only the selected FIFO's occupancy, never consumer ready; a stalled channel never blocks the other.
import demux_1_to_2_buffered_pkg::*;

module demux_1_to_2_buffered #(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int CNTW     = DEF_CNTW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    demux_1_to_2_buffered_if.slave   bus
);
    logic full_1;
    logic full_2;
    logic sel_2;
    logic accept;
    logic push_1;
    logic push_2;

    assign full_1 = (bus.count_1 == CNTW'(DEPTH));
    assign full_2 = (bus.count_2 == CNTW'(DEPTH));
    assign sel_2  = (bus.CTRL == SEL_OUT_2);

    assign bus.in_ready = !rst && !flush && (sel_2 ? !full_2 : !full_1);

    // in_valid gates everything so an undriven CTRL/in_data while idle cannot cause a write.
    assign accept = bus.in_valid && bus.in_ready;
    assign push_1 = accept && !sel_2;
    assign push_2 = accept && sel_2;

    demux_fifo #(
        .BITWIDTH (BITWIDTH),
        .DEPTH    (DEPTH),
        .CNTW     (CNTW)
    ) u_fifo_1 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push_1),
        .push_data  (bus.in_data),
        .pop_ready  (bus.out_1_ready),
        .head_data  (bus.out_1_data),
        .head_valid (bus.out_1_valid),
        .count      (bus.count_1)
    );

    demux_fifo #(
        .BITWIDTH (BITWIDTH),
        .DEPTH    (DEPTH),
        .CNTW     (CNTW)
    ) u_fifo_2 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push_2),
        .push_data  (bus.in_data),
        .pop_ready  (bus.out_2_ready),
        .head_data  (bus.out_2_data),
        .head_valid (bus.out_2_valid),
        .count      (bus.count_2)
    );

endmodule

// File: tb/tb_demux_1_to_2_buffered.sv
// Randomised and directed bench for demux_1_to_2_buffered with a per-channel queue scoreboard.
module tb_demux_1_to_2_buffered;
    localparam int BW    = 32;
    localparam int DEPTH = 2;
    localparam int CNTW  = 2;

    logic clk;
    logic rst;
    logic flush;
    bit   started;
    int   errors;
    int   checks;

    logic [BW-1:0] q1[$];
    logic [BW-1:0] q2[$];
    logic          exp_rdy;

    demux_1_to_2_buffered_if #(.BITWIDTH(BW), .CNTW(CNTW)) bus();

    demux_1_to_2_buffered #(.BITWIDTH(BW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the model is two plain queues; occupancy, head, valid and ready all derive from them.
    always @(negedge clk) begin
        if (started) begin
            exp_rdy = !rst && !flush &&
                      (bus.CTRL ? (q2.size() < DEPTH) : (q1.size() < DEPTH));
            chk("in_ready",    32'(bus.in_ready),    32'(exp_rdy));
            chk("count_1",     32'(bus.count_1),     32'(q1.size()));
            chk("count_2",     32'(bus.count_2),     32'(q2.size()));
            chk("out_1_valid", 32'(bus.out_1_valid), 32'(q1.size() > 0));
            chk("out_2_valid", 32'(bus.out_2_valid), 32'(q2.size() > 0));
            chk("out_1_data",  bus.out_1_data, (q1.size() > 0) ? q1[0] : '0);
            chk("out_2_data",  bus.out_2_data, (q2.size() > 0) ? q2[0] : '0);
            if (rst || flush) begin
                q1.delete();
                q2.delete();
            end else begin
                if (q1.size() > 0 && bus.out_1_ready) void'(q1.pop_front());
                if (q2.size() > 0 && bus.out_2_ready) void'(q2.pop_front());
                if (bus.in_valid && exp_rdy) begin
                    if (bus.CTRL) q2.push_back(bus.in_data);
                    else          q1.push_back(bus.in_data);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic c, input logic [BW-1:0] d);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.CTRL     = c;
        bus.in_data  = d;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: got no accept expected accept for data %h", d);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        started = 1'b0;
        rst     = 1'b1;
        flush   = 1'b0;
        bus.in_valid    = 1'b1;
        bus.CTRL        = 1'b0;
        bus.in_data     = 32'hDEAD_BEEF;
        bus.out_1_ready = 1'b1;
        bus.out_2_ready = 1'b1;
        @(posedge clk);
        started = 1'b1;
        #1;
        step(1);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        step(1);

        // Steering
        send(1'b0, 32'hAAAA_0001);
        send(1'b1, 32'hBBBB_0002);
        step(3);

        // Full channel 1 does not block channel 2
        bus.out_1_ready = 1'b0;
        send(1'b0, 32'h1);
        send(1'b0, 32'h2);
        bus.in_valid = 1'b1;
        bus.CTRL     = 1'b0;
        bus.in_data  = 32'h9;
        step(2);
        bus.in_valid = 1'b0;
        send(1'b1, 32'h3);
        bus.out_1_ready = 1'b1;
        step(4);

        // Push/pop at full and at empty on channel 2
        bus.out_2_ready = 1'b0;
        send(1'b1, 32'h21);
        send(1'b1, 32'h22);
        bus.out_2_ready = 1'b1;
        send(1'b1, 32'h23);
        step(4);
        send(1'b1, 32'h24);
        step(3);

        // Wrap-around with a toggling consumer
        fork
            begin
                for (int i = 0; i < 16; i++) send(1'b0, 32'h10 + 32'(i));
            end
            begin
                for (int k = 0; k < 80; k++) begin
                    bus.out_1_ready = k[0];
                    @(posedge clk);
                    #1;
                end
            end
        join
        bus.out_1_ready = 1'b1;
        step(3);

        // Flush with both FIFOs full and a concurrent push
        bus.out_1_ready = 1'b0;
        bus.out_2_ready = 1'b0;
        send(1'b0, 32'h31);
        send(1'b0, 32'h32);
        send(1'b1, 32'h41);
        send(1'b1, 32'h42);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.CTRL     = 1'b1;
        bus.in_data  = 32'h99;
        step(1);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_2_ready = 1'b1;
        send(1'b1, 32'h55);
        step(3);

        // Reset mid-operation
        bus.out_1_ready = 1'b0;
        bus.out_2_ready = 1'b0;
        send(1'b0, 32'h61);
        send(1'b1, 32'h71);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        step(1);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_1_ready = 1'b1;
        bus.out_2_ready = 1'b1;
        step(2);

        // Random traffic including occasional flush and reset
        for (int n = 0; n < 600; n++) begin
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.CTRL        = 1'($urandom_range(0, 1));
            bus.in_data     = $urandom;
            bus.out_1_ready = ($urandom_range(0, 2) != 0);
            bus.out_2_ready = ($urandom_range(0, 3) == 0);
            flush           = ($urandom_range(0, 40) == 0);
            rst             = ($urandom_range(0, 80) == 0);
            step(1);
        end
        rst   = 1'b0;
        flush = 1'b0;
        bus.in_valid    = 1'b0;
        bus.out_1_ready = 1'b1;
        bus.out_2_ready = 1'b1;
        step(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
